mem_access_unit: RTL

- MEM-stage data-memory initiator for the RV32I pipeline.
- Consumes the control word's memory fields: write, read_b (load), funct3, plus ALU address and rs2 data.
- Issues a word-aligned request/response transaction to the data cache and aligns store data and byte enables.
- Extracts and sign/zero-extends load data, and stalls the pipeline until the access completes.

---
 rtl/rv32i_types.sv | 73 +++++++
 rtl/load_extend.sv | 39 +++
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// ============================================================================
//  Module   : rv32i_types (package)
//  Purpose  : Shared RV32I type definitions: load/store funct3 encodings,
//             the MEM-stage access-unit state type, and helpers that decode
//             access width and alignment from funct3 and the low address bits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mau_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } access_size_t;

    // Stores only define sb/sh/sw; loads add the unsigned variants.
    // Any other code falls back to word width.
    function automatic access_size_t access_size(input logic       is_store,
                                                 input logic [2:0] f3);
        access_size_t sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (f3)
                sb:      sz = SZ_BYTE;
                sh:      sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                lb, lbu: sz = SZ_BYTE;
                lh, lhu: sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_aligned(input access_size_t sz,
                                        input logic [1:0]   offset);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~offset[0];
            default: ok = (offset == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
//  Module   : load_extend
//  Purpose  : Selects the addressed byte/halfword lane of a cache read word
//             and sign- or zero-extends it according to the load funct3.
//  Ports    : rdata  (in, 32)  cache read word
//             offset (in, 2)   byte offset addr[1:0] of the load
//             funct3 (in, 3)   load width code
//             result (out, 32) extended load value
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[{offset, 3'b000} +: 8];
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            lb:      result = {{24{w_byte[7]}}, w_byte};
            lbu:     result = {24'h0, w_byte};
            lh:      result = {{16{w_half[15]}}, w_half};
            lhu:     result = {16'h0, w_half};
            default: result = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage data-memory initiator. Checks alignment, issues a
//             word-aligned request with lane-aligned store data and byte
//             enables, waits for the cache response, extends load data and
//             stalls the pipeline until the access completes.
//  Ports    : clk, rst (sync, active-high)
//             valid, ctrl_read, ctrl_write, funct3, addr, rs2_data  - MEM inputs
//             mem_rdata, mem_resp                                    - cache response
//             mem_read, mem_write, mem_address, mem_byte_enable,
//             mem_wdata                                              - cache request
//             load_data, done, stall, misaligned, timeout_err        - pipeline side
//  Config   : MEM_TIMEOUT_EN - enables the BUSY response watchdog
//             (TIMEOUT_CYCLES); without it timeout_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import rv32i_types::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        ctrl_read,
    input  logic        ctrl_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        misaligned,
    output logic        timeout_err
);

    mau_state_t   r_state;
    mau_state_t   w_state_next;
    logic [2:0]   r_funct3;
    logic [1:0]   r_offset;

    logic         w_access;
    access_size_t w_size;
    logic         w_aligned;
    logic         w_start;
    logic         w_misalign;
    logic         w_finish;
    logic         w_timeout;
    logic [3:0]   w_be;
    logic [31:0]  w_wdata;
    logic [31:0]  w_ext;

    // ---------------------------------------------------------------- decode
    // A store wins when both read and write are flagged.
    assign w_access  = valid & (ctrl_read | ctrl_write);
    assign w_size    = access_size(ctrl_write, funct3);
    assign w_aligned = is_aligned(w_size, addr[1:0]);

    // While the misaligned pulse is high the same held instruction is
    // masked so it cannot raise a second trap pulse back-to-back.
    assign w_start    = (r_state == IDLE) & w_access & w_aligned  & ~misaligned;
    assign w_misalign = (r_state == IDLE) & w_access & ~w_aligned & ~misaligned;
    assign w_finish   = (r_state == BUSY) & (mem_resp | w_timeout);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2_data;
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{rs2_data[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << addr[1:0];
                w_wdata = {2{rs2_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = rs2_data;
            end
        endcase
    end

    load_extend u_load_extend (
        .rdata  (mem_rdata),
        .offset (r_offset),
        .funct3 (r_funct3),
        .result (w_ext)
    );

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start)  w_state_next = BUSY;
            BUSY:    if (w_finish) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        stall = w_start | (r_state == BUSY);
        done  = (r_state == DONE);
    end

    // ----------------------------------------------------- request/response
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= 32'h0;
            mem_byte_enable <= 4'h0;
            mem_wdata       <= 32'h0;
            load_data       <= 32'h0;
            misaligned      <= 1'b0;
            r_funct3        <= 3'b000;
            r_offset        <= 2'b00;
        end else begin
            misaligned <= w_misalign;
            if (w_start) begin
                mem_read        <= ctrl_read & ~ctrl_write;
                mem_write       <= ctrl_write;
                mem_address     <= {addr[31:2], 2'b00};
                mem_byte_enable <= w_be;
                mem_wdata       <= w_wdata;
                r_funct3        <= funct3;
                r_offset        <= addr[1:0];
            end else if (w_finish) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                // A real response takes priority over a same-cycle watchdog.
                if (mem_resp) begin
                    if (mem_read) begin
                        load_data <= w_ext;
                    end
                end else begin
                    load_data <= 32'h0;
                end
            end
        end
    end

    // -------------------------------------------------------------- watchdog
`ifdef MEM_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_wd_cnt;
    logic               r_timeout_err;

    // Counts completed BUSY cycles; fires on the TIMEOUT_CYCLES-th one.
    assign w_timeout = (r_state == BUSY) & ~mem_resp &
                       (r_wd_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if ((r_state == BUSY) && !w_finish) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign timeout_err      = 1'b0;
`endif

endmodule

`default_nettype wire
